alu_bist: RTL and testbench

Built-in self-test controller that drives the single-cycle datapath ALU's control/operand interface (alucont, rd1, rd2) and compacts its responses (res, zero).
- Two LFSRs generate operand pairs; each pair is applied under all six ALU operations.
- A MISR folds every result into a 32-bit signature, which is compared against a golden value at the end.
- Sits beside the alu, muxed onto its inputs in test mode.

---
 rtl/alu_bist_if.sv | 25 ++
 rtl/alu_bist.sv | 110 +++++++++++
 tb/tb_alu_bist.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_bist_if.sv
// Control/operand and response bundle between the ALU BIST controller and the ALU it exercises.
// The master side is the BIST controller; the slave side is the ALU plus whoever issues start.
interface alu_bist_if;
  logic        start;
  logic [3:0]  alucont;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] res;
  logic        zero;
  logic        busy;
  logic        done;
  logic        pass;
  logic        zero_err;
  logic [31:0] signature;

  modport master (
    input  start, res, zero,
    output alucont, rd1, rd2, busy, done, pass, zero_err, signature
  );

  modport slave (
    output start, res, zero,
    input  alucont, rd1, rd2, busy, done, pass, zero_err, signature
  );
endinterface

// File: rtl/alu_bist.sv
// ALU built-in self-test: two LFSRs feed operand pairs under all six ops and a MISR compacts the responses.
// A run takes NUM_VECTORS*6 cycles after the start edge; pass is registered on the edge entering DONE.
module alu_bist #(
  parameter int unsigned NUM_VECTORS = 64,
  parameter logic [31:0] SEED_A      = 32'hACE1_2468,
  parameter logic [31:0] SEED_B      = 32'h1357_9BDF,
  parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       reset,
  alu_bist_if.master bus
);
  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_RUN  = 2'd1;
  localparam logic [1:0]  S_DONE = 2'd2;

  localparam logic [31:0] MISR_POLY = 32'h0040_0007;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [31:0] L_SEED_A  = (SEED_A == 32'b0) ? 32'h1 : SEED_A;
  localparam logic [31:0] L_SEED_B  = (SEED_B == 32'b0) ? 32'h1 : SEED_B;
  localparam logic [15:0] LAST_VEC  = 16'(NUM_VECTORS - 1);

  logic [1:0]  r_state;
  logic [2:0]  r_op;
  logic [15:0] r_vec;
  logic [31:0] r_lfsr_a;
  logic [31:0] r_lfsr_b;
  logic [31:0] r_sig;
  logic        r_zerr;
  logic        r_pass;

  logic        w_run;
  logic        w_start;
  logic        w_wrap;
  logic        w_last;
  logic [3:0]  w_op_code;
  logic [31:0] w_sig_next;
  logic        w_zerr_next;
  logic [31:0] w_lfsr_a_next;
  logic [31:0] w_lfsr_b_next;

  assign w_run   = (r_state == S_RUN);
  assign w_start = bus.start && !w_run;
  assign w_wrap  = (r_op == 3'd5);
  assign w_last  = w_wrap && (r_vec == LAST_VEC);

  always_comb begin
    w_op_code = 4'b0000;
    case (r_op)
      3'd0:    w_op_code = 4'b0000;
      3'd1:    w_op_code = 4'b0001;
      3'd2:    w_op_code = 4'b0010;
      3'd3:    w_op_code = 4'b0110;
      3'd4:    w_op_code = 4'b0111;
      3'd5:    w_op_code = 4'b1100;
      default: w_op_code = 4'b0000;
    endcase
  end

  assign w_sig_next    = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? MISR_POLY : 32'b0)
                         ^ bus.res ^ {31'b0, bus.zero};
  assign w_zerr_next   = r_zerr | (bus.zero != (bus.res == 32'b0));
  assign w_lfsr_a_next = {1'b0, r_lfsr_a[31:1]} ^ (r_lfsr_a[0] ? LFSR_POLY : 32'b0);
  assign w_lfsr_b_next = {1'b0, r_lfsr_b[31:1]} ^ (r_lfsr_b[0] ? LFSR_POLY : 32'b0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= 3'd0;
      r_vec    <= 16'd0;
      r_lfsr_a <= 32'b0;
      r_lfsr_b <= 32'b0;
      r_sig    <= 32'b0;
      r_zerr   <= 1'b0;
      r_pass   <= 1'b0;
    end else if (w_start) begin
      r_state  <= S_RUN;
      r_op     <= 3'd0;
      r_vec    <= 16'd0;
      r_lfsr_a <= L_SEED_A;
      r_lfsr_b <= L_SEED_B;
      r_sig    <= 32'b0;
      r_zerr   <= 1'b0;
      r_pass   <= 1'b0;
    end else if (w_run) begin
      r_sig  <= w_sig_next;
      r_zerr <= w_zerr_next;
      r_op   <= w_wrap ? 3'd0 : r_op + 3'd1;
      if (w_wrap) begin
        r_lfsr_a <= w_lfsr_a_next;
        r_lfsr_b <= w_lfsr_b_next;
        r_vec    <= r_vec + 16'd1;
      end
      if (w_last) begin
        r_state <= S_DONE;
        r_pass  <= (w_sig_next == GOLDEN_SIG) && !w_zerr_next;
      end
    end
  end

  assign bus.busy      = w_run;
  assign bus.done      = (r_state == S_DONE);
  assign bus.alucont   = w_run ? w_op_code : 4'b0000;
  assign bus.rd1       = w_run ? r_lfsr_a : 32'b0;
  assign bus.rd2       = w_run ? r_lfsr_b : 32'b0;
  assign bus.signature = r_sig;
  assign bus.zero_err  = r_zerr;
  assign bus.pass      = r_pass;
endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: five instances with different seeds/goldens, a behavioural ALU, and a per-application model.
module tb_alu_bist;
  localparam int NDUT = 5;
  localparam int unsigned P_NV [NDUT] = '{64, 1, 1, 1, 2};
  localparam logic [31:0] P_SA [NDUT] = '{32'hACE1_2468, 32'hFF, 32'hFF, 32'hFF, 32'h0};
  localparam logic [31:0] P_SB [NDUT] = '{32'h1357_9BDF, 32'h0F, 32'h0F, 32'h0F, 32'h2};
  localparam logic [31:0] P_GS [NDUT] = '{32'h0, 32'hFFFF_FAA2, 32'hFFFF_FAA3, 32'hFFFF_FAA2, 32'h0};
  localparam logic        P_FZ [NDUT] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [3:0]  OPS  [6]    = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};
  localparam logic [1:0]  M_IDLE = 2'd0, M_RUN = 2'd1, M_DONE = 2'd2;

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] n;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sig;
    logic        zerr;
    logic        pass;
  } mst_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NDUT-1:0] start_v = '0;
  logic [3:0]      o_alucont [NDUT];
  logic [31:0]     o_rd1 [NDUT];
  logic [31:0]     o_rd2 [NDUT];
  logic [31:0]     o_sig [NDUT];
  logic            o_busy [NDUT];
  logic            o_done [NDUT];
  logic            o_pass [NDUT];
  logic            o_zerr [NDUT];
  mst_t            m [NDUT];
  int              n_chk = 0;
  int              n_pass = 0;
  int              busy_cnt;
  logic [31:0]     sig1;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h0:    return a & b;
      4'h1:    return a | b;
      4'h2:    return a + b;
      4'h6:    return a - b;
      4'h7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hC:    return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic zero_f(input int g, input logic [31:0] r);
    return (r == 32'd0) || (P_FZ[g] && r == 32'h10E);
  endfunction

  function automatic logic [31:0] lfsr_f(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'd0);
  endfunction

  generate
    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
      alu_bist_if bus();
      assign bus.start    = start_v[g];
      assign bus.res      = alu_f(bus.alucont, bus.rd1, bus.rd2);
      assign bus.zero     = zero_f(g, bus.res);
      assign o_alucont[g] = bus.alucont;
      assign o_rd1[g]     = bus.rd1;
      assign o_rd2[g]     = bus.rd2;
      assign o_sig[g]     = bus.signature;
      assign o_busy[g]    = bus.busy;
      assign o_done[g]    = bus.done;
      assign o_pass[g]    = bus.pass;
      assign o_zerr[g]    = bus.zero_err;
      alu_bist #(
        .NUM_VECTORS(P_NV[g]), .SEED_A(P_SA[g]), .SEED_B(P_SB[g]), .GOLDEN_SIG(P_GS[g])
      ) u_dut (
        .clk(clk), .reset(reset), .bus(bus.master)
      );
    end
  endgenerate

  // Model advances one ALU application per clock; vector and op follow from the application count n.
  function automatic mst_t mstep(input mst_t s, input logic st, input int g);
    mst_t t = s;
    logic [31:0] r;
    logic z;
    if (s.mode != M_RUN && st) begin
      t.mode = M_RUN; t.n = 0; t.sig = 0; t.zerr = 0; t.pass = 0;
      t.a = (P_SA[g] == 0) ? 32'd1 : P_SA[g];
      t.b = (P_SB[g] == 0) ? 32'd1 : P_SB[g];
    end else if (s.mode == M_RUN) begin
      r = alu_f(OPS[s.n % 6], s.a, s.b);
      z = zero_f(g, r);
      t.sig  = (s.sig << 1) ^ (s.sig[31] ? 32'h0040_0007 : 32'd0) ^ r ^ 32'(z);
      t.zerr = s.zerr | (z != (r == 0));
      t.n    = s.n + 1;
      if (t.n % 6 == 0) begin
        t.a = lfsr_f(s.a);
        t.b = lfsr_f(s.b);
      end
      if (t.n == P_NV[g] * 6) begin
        t.mode = M_DONE;
        t.pass = (t.sig == P_GS[g]) && !t.zerr;
      end
    end
    return t;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int g = 0; g < NDUT; g++)
      m[g] <= reset ? '0 : mstep(m[g], start_v[g], g);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(posedge clk) begin
    #2;
    if (!reset) begin
      for (int g = 0; g < NDUT; g++) begin
        chk($sformatf("g%0d_busy", g), 32'(o_busy[g]), 32'(m[g].mode == M_RUN));
        chk($sformatf("g%0d_done", g), 32'(o_done[g]), 32'(m[g].mode == M_DONE));
        chk($sformatf("g%0d_alucont", g), 32'(o_alucont[g]),
            (m[g].mode == M_RUN) ? 32'(OPS[m[g].n % 6]) : 32'd0);
        chk($sformatf("g%0d_rd1", g), o_rd1[g], (m[g].mode == M_RUN) ? m[g].a : 32'd0);
        chk($sformatf("g%0d_rd2", g), o_rd2[g], (m[g].mode == M_RUN) ? m[g].b : 32'd0);
        chk($sformatf("g%0d_sig", g), o_sig[g], m[g].sig);
        chk($sformatf("g%0d_zerr", g), 32'(o_zerr[g]), 32'(m[g].zerr));
        chk($sformatf("g%0d_pass", g), 32'(o_pass[g]), 32'(m[g].pass));
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of a 64-vector run
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrun_busy_before_reset", 32'(o_busy[0]), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_busy", 32'(o_busy[0]), 32'd0);
    chk("rst_done", 32'(o_done[0]), 32'd0);
    chk("rst_pass", 32'(o_pass[0]), 32'd0);
    chk("rst_zerr", 32'(o_zerr[0]), 32'd0);
    chk("rst_sig", o_sig[0], 32'd0);
    chk("rst_alucont", 32'(o_alucont[0]), 32'd0);
    chk("rst_rd1", o_rd1[0], 32'd0);
    chk("rst_rd2", o_rd2[0], 32'd0);
    @(negedge clk); reset = 1'b0;

    // Single-vector runs with real and faulty ALUs, plus the zero-seed run
    @(negedge clk); start_v = 5'b11110;
    @(negedge clk); start_v = '0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("v1_rd1_%0d", k), o_rd1[1], 32'hFF);
      chk($sformatf("v1_rd2_%0d", k), o_rd2[1], 32'h0F);
      chk($sformatf("v1_op_%0d", k), 32'(o_alucont[1]), 32'(OPS[k]));
      chk($sformatf("v1_busy_%0d", k), 32'(o_busy[1]), 32'd1);
      if (k == 0) begin
        chk("seed0_rd1", o_rd1[4], 32'h1);
        chk("seed0_rd2", o_rd2[4], 32'h2);
      end
      if (k == 2) chk("fz_zerr_before_add", 32'(o_zerr[3]), 32'd0);
      if (k == 3) chk("fz_zerr_after_add", 32'(o_zerr[3]), 32'd1);
      @(negedge clk);
    end
    chk("v1_done", 32'(o_done[1]), 32'd1);
    chk("v1_busy_end", 32'(o_busy[1]), 32'd0);
    chk("v1_sig", o_sig[1], 32'hFFFF_FAA2);
    chk("v1_pass", 32'(o_pass[1]), 32'd1);
    chk("badgold_pass", 32'(o_pass[2]), 32'd0);
    chk("badgold_zerr", 32'(o_zerr[2]), 32'd0);
    chk("fz_sig", o_sig[3], 32'hFFFF_FAAA);
    chk("fz_zerr", 32'(o_zerr[3]), 32'd1);
    chk("fz_pass", 32'(o_pass[3]), 32'd0);
    chk("seed0_v1_rd1", o_rd1[4], 32'h8020_0003);
    chk("seed0_v1_rd2", o_rd2[4], 32'h1);
    repeat (8) @(negedge clk);

    // start held through RUN must not restart or stretch the run
    start_v[0] = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (o_busy[0]) busy_cnt++;
      if (k == 383) start_v[0] = 1'b0;
      if (o_done[0]) break;
    end
    chk("held_start_run_len", 32'(busy_cnt), 32'd384);
    chk("held_start_done", 32'(o_done[0]), 32'd1);
    sig1 = o_sig[0];
    repeat (3) @(negedge clk);

    // Restart from DONE reproduces the signature
    start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    chk("restart_done_drop", 32'(o_done[0]), 32'd0);
    chk("restart_pass_drop", 32'(o_pass[0]), 32'd0);
    chk("restart_busy", 32'(o_busy[0]), 32'd1);
    for (int k = 0; k < 400; k++) begin
      if (o_done[0]) break;
      @(negedge clk);
    end
    chk("restart_done", 32'(o_done[0]), 32'd1);
    chk("restart_sig_same", o_sig[0], sig1);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
